// File: rtl/byte_serial_add_ctrl_pkg.sv
// adder_ctrl_pkg: constants and the state encoding shared by the byte-serial
// adder sequencer and its 8-bit adder slice.
//   BYTE_W  width of the time-shared adder slice
//   state_t FSM encoding (ST_IDLE = 1'b0, ST_RUN = 1'b1)
// Optional feature macro used by the files that import this package: SUBTRACT_EN.
package adder_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/byte_serial_add_ctrl_if.sv
// byte_serial_add_ctrl_if: start/busy/done handshake plus operand and result
// buses between the issuing control logic (master) and the sequencer (slave).
//   start, a, b, cin, sub(SUBTRACT_EN only)  master -> slave
//   busy, done, sum, cout, ovf               slave  -> master
// Macro: SUBTRACT_EN adds the sub signal.
interface byte_serial_add_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SUBTRACT_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

`ifdef SUBTRACT_EN
  modport master (output start, a, b, cin, sub,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, a, b, cin, sub,
                  output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, a, b, cin,
                  output busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/byte_add8.sv
// byte_add8: combinational 8-bit ripple-carry adder slice.
//   a, b  in   8  addend bytes
//   ci    in   1  carry in
//   s     out  8  sum byte
//   co    out  1  carry out of bit 7
module byte_add8
  import adder_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl: adds two NBYTES-wide operands one byte per clock,
// LSB first, through a single shared byte_add8 slice and a carry register.
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of byte_serial_add_ctrl_if
//          (start/a/b/cin[/sub] in; busy/done/sum/cout/ovf out)
// Macro: SUBTRACT_EN enables bus.sub (A-B via ~b and forced carry-in of 1).
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; sum/cout/ovf hold the last result
// ST_RUN  | one byte added per edge at idx; leaves after idx NBYTES-1
module byte_serial_add_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  byte_serial_add_ctrl_if.slave bus
);

  localparam int W    = BYTE_W * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [W-1:0]      op_a_q;
  logic [W-1:0]      op_b_q;
  logic [W-1:0]      sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              done_q;

  logic              accept;
  logic              last;
  logic [W-1:0]      b_eff;
  logic              c_init;
  logic [BYTE_W-1:0] slice_a;
  logic [BYTE_W-1:0] slice_b;
  logic [BYTE_W-1:0] slice_s;
  logic              slice_co;

  // The effective B operand is stored, so the overflow test below compares
  // against what was actually added (for subtraction that is ~b).
`ifdef SUBTRACT_EN
  assign b_eff  = bus.sub ? ~bus.b : bus.b;
  assign c_init = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff  = bus.b;
  assign c_init = bus.cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          accept  = 1'b1;
        end
      end
      ST_RUN: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          last    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign slice_a = op_a_q[BYTE_W*idx_q +: BYTE_W];
  assign slice_b = op_b_q[BYTE_W*idx_q +: BYTE_W];

  byte_add8 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        op_a_q  <= bus.a;
        op_b_q  <= b_eff;
        carry_q <= c_init;
        idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
        sum_q[BYTE_W*idx_q +: BYTE_W] <= slice_s;
        carry_q <= slice_co;
        if (last) begin
          cout_q <= slice_co;
          // slice_s[BYTE_W-1] is the result sign bit being written this edge
          ovf_q  <= (op_a_q[W-1] == op_b_q[W-1]) &&
                    (slice_s[BYTE_W-1] != op_a_q[W-1]);
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
